// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the bit-serial add/subtract datapath.
//   OP_ADD / OP_SUB : encoding of the op request bit
//   state_t         : two-bit FSM state encoding (S_IDLE, S_RUN, S_DONE)
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
// Request/response bundle of the bit-serial adder/subtractor.
//   start, op, a, b           : request side, driven by the master
//   busy, done                : handshake status, driven by the slave
//   result, cf, zf, vf, sf    : result word and ALU flags, driven by the slave
// Modports:
//   master : the requester (ALU control, testbench)
//   slave  : the serial_addsub datapath
interface serial_addsub_if #(
  parameter int N = 32
);

  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cf;
  logic         zf;
  logic         vf;
  logic         sf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cf, zf, vf, sf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cf, zf, vf, sf
  );

endinterface

// File: rtl/serial_addsub_fa.sv
// serial_addsub_fa
// Single-bit full-adder cell, the only arithmetic element of the serial datapath.
//   a, b : operand bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : majority of a, b, cin
module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Purely combinational; the carry is stored by the caller between bits.
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial N-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first. A request is accepted in IDLE or DONE, the
// N bits are computed in RUN, and DONE presents a one-cycle done pulse with
// the result and RISC-V-style flags (carry, zero, overflow, sign).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (priority over everything)
//   bus : serial_addsub_if slave modport (start/op/a/b in, busy/done/result/flags out)
// Parameters:
//   N  : operand/result width (N >= 2)
//   CW : bit-counter width
module serial_addsub
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  state_t state_q, state_d;

  logic [N-1:0]  aSh_q, aSh_d;
  logic [N-1:0]  bSh_q, bSh_d;
  logic [N-1:0]  resultSh_q, resultSh_d;
  logic [N-1:0]  result_q, result_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  logic          cf_q, cf_d;
  logic          zf_q, zf_d;
  logic          vf_q, vf_d;
  logic          sf_q, sf_d;

  logic          accept;
  logic          lastBit;
  logic          faSum;
  logic          faCout;
  logic [N-1:0]  finalResult;

  // A request is taken whenever we are not shifting; this covers both IDLE
  // and the back-to-back case where start arrives during the DONE cycle.
  assign accept  = (state_q != S_RUN) && bus.start;
  assign lastBit = (state_q == S_RUN) && (count_q == CW'(N - 1));

  // The final sum bit lands at the MSB while the earlier bits are already
  // sitting in the upper part of the shift register.
  assign finalResult = {faSum, resultSh_q[N-1:1]};

  serial_addsub_fa uFa (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .cin  (carry_q),
    .sum  (faSum),
    .cout (faCout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE lasts a single cycle and either chains straight
  // into a new RUN or falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (lastBit)   state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs depend on the state only.
  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  // Datapath next-state. Subtraction is a + ~b + 1: b is inverted on load
  // and the +1 rides in as the initial carry. On the last bit the carry into
  // the MSB is still in carry_q, so overflow is carry_q ^ final carry-out.
  always_comb begin
    aSh_d      = aSh_q;
    bSh_d      = bSh_q;
    resultSh_d = resultSh_q;
    result_d   = result_q;
    count_d    = count_q;
    carry_d    = carry_q;
    cf_d       = cf_q;
    zf_d       = zf_q;
    vf_d       = vf_q;
    sf_d       = sf_q;
    if (accept) begin
      aSh_d   = bus.a;
      bSh_d   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
      carry_d = (bus.op == OP_SUB);
      count_d = '0;
    end else if (state_q == S_RUN) begin
      aSh_d      = aSh_q >> 1;
      bSh_d      = bSh_q >> 1;
      resultSh_d = finalResult;
      carry_d    = faCout;
      count_d    = count_q + CW'(1);
      if (lastBit) begin
        result_d = finalResult;
        cf_d     = faCout;
        vf_d     = carry_q ^ faCout;
        zf_d     = (finalResult == '0);
        sf_d     = faSum;
      end
    end
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      aSh_q      <= '0;
      bSh_q      <= '0;
      resultSh_q <= '0;
      result_q   <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      vf_q       <= 1'b0;
      sf_q       <= 1'b0;
    end else begin
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      resultSh_q <= resultSh_d;
      result_q   <= result_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      cf_q       <= cf_d;
      zf_q       <= zf_d;
      vf_q       <= vf_d;
      sf_q       <= sf_d;
    end
  end

  // Result and flags are registered and held until the next DONE entry.
  always_comb begin
    bus.result = result_q;
    bus.cf     = cf_q;
    bus.zf     = zf_q;
    bus.vf     = vf_q;
    bus.sf     = sf_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Self-checking bench for serial_addsub at N=32 (directed table plus
// handshake and reset sequences) and N=8 (corner-value grid plus random
// operands against an arithmetic reference model). Expected results are
// queued when a request is driven and popped when the DUT raises done.
module tb_serial_addsub;
  import alu_pkg::*;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cf;
    logic        zf;
    logic        vf;
    logic        sf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  serial_addsub_if #(.N(32)) bus32 ();
  serial_addsub_if #(.N(8))  bus8 ();

  serial_addsub #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  serial_addsub #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  vec_t q32[$];
  vec_t q8[$];
  vec_t mon32;
  vec_t mon8;
  vec_t tbl32[10];
  int   vectorCount = 0;
  int   missCount   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkResult(input string tag, input vec_t e, input logic [31:0] r,
                             input logic cf, input logic zf, input logic vf, input logic sf);
    checkOutput({tag, " result"}, r, e.res);
    checkBit({tag, " cf"}, cf, e.cf);
    checkBit({tag, " zf"}, zf, e.zf);
    checkBit({tag, " vf"}, vf, e.vf);
    checkBit({tag, " sf"}, sf, e.sf);
  endtask

  // Reference model for N=8 written with whole-word arithmetic.
  function automatic vec_t model8(input logic op, input logic [7:0] a, input logic [7:0] b);
    vec_t m;
    int   s;
    logic [7:0] r;
    r = (op == OP_SUB) ? (a - b) : (a + b);
    s = (op == OP_SUB) ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    m.op  = op;
    m.a   = {24'b0, a};
    m.b   = {24'b0, b};
    m.res = {24'b0, r};
    m.cf  = (op == OP_SUB) ? (a >= b) : ((int'(a) + int'(b)) > 255);
    m.zf  = (r == 8'd0);
    m.vf  = (s > 127) || (s < -128);
    m.sf  = r[7];
    return m;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) begin
        vectorCount++;
        missCount++;
        $display("[TB] FAIL n32 unexpected done: got result 0x%0h, expected no done", bus32.result);
      end else begin
        mon32 = q32.pop_front();
        checkResult("n32", mon32, bus32.result, bus32.cf, bus32.zf, bus32.vf, bus32.sf);
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        vectorCount++;
        missCount++;
        $display("[TB] FAIL n8 unexpected done: got result 0x%0h, expected no done", bus8.result);
      end else begin
        mon8 = q8.pop_front();
        checkResult("n8", mon8, {24'b0, bus8.result}, bus8.cf, bus8.zf, bus8.vf, bus8.sf);
      end
    end
  end

  // Drives one N=32 request, scrambles the inputs after acceptance and waits
  // (bounded) for done; latency counts clock edges from the accepting edge.
  task automatic applyStimulus(input vec_t e, output int latency, output int busyCycles);
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = e.op;
    bus32.a     = e.a;
    bus32.b     = e.b;
    q32.push_back(e);
    latency    = 0;
    busyCycles = 0;
    do begin
      @(negedge clk);
      latency++;
      if (latency == 1) begin
        bus32.start = 1'b0;
        bus32.op    = 1'($urandom_range(0, 1));
        bus32.a     = $urandom();
        bus32.b     = $urandom();
      end
      if (bus32.busy === 1'b1) busyCycles++;
    end while (bus32.done !== 1'b1 && latency < 60);
    if (bus32.done !== 1'b1) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL n32 done timeout: got no done, expected done within 60 cycles");
    end
  endtask

  task automatic applyStimulus8(input logic op, input logic [7:0] a, input logic [7:0] b);
    int lat;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    q8.push_back(model8(op, a, b));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom());
        bus8.b     = 8'($urandom());
      end
    end while (bus8.done !== 1'b1 && lat < 30);
    checkOutput("n8 latency", lat, 32'd9);
  endtask

  initial begin
    int   lat;
    int   bc;
    vec_t e;
    logic [7:0] corner[8];

    tbl32[0] = '{OP_ADD, 32'd5,          32'd3,          32'd8,          1'b0, 1'b0, 1'b0, 1'b0};
    tbl32[1] = '{OP_ADD, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    tbl32[2] = '{OP_ADD, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b0, 1'b1, 1'b1};
    tbl32[3] = '{OP_SUB, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl32[4] = '{OP_SUB, 32'd5,          32'd5,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    tbl32[5] = '{OP_SUB, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl32[6] = '{OP_ADD, 32'h80000000,   32'h80000000,   32'd0,          1'b1, 1'b1, 1'b1, 1'b0};
    tbl32[7] = '{OP_SUB, 32'd0,          32'd0,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    tbl32[8] = '{OP_SUB, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl32[9] = '{OP_SUB, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1'b0, 1'b1, 1'b1};

    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h02; corner[3] = 8'h7F;
    corner[4] = 8'h80; corner[5] = 8'h81; corner[6] = 8'hFE; corner[7] = 8'hFF;

    rst = 1'b1;
    bus32.start = 1'b0; bus32.op = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(negedge clk);
    checkBit("reset busy", bus32.busy, 1'b0);
    checkBit("reset done", bus32.done, 1'b0);
    checkOutput("reset result", bus32.result, 32'd0);
    checkBit("reset cf", bus32.cf, 1'b0);
    checkBit("reset zf", bus32.zf, 1'b0);
    checkBit("reset vf", bus32.vf, 1'b0);
    checkBit("reset sf", bus32.sf, 1'b0);
    checkOutput("reset n8 result", {24'b0, bus8.result}, 32'd0);
    rst = 1'b0;

    // Directed N=32 table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl32[i], lat, bc);
      checkOutput($sformatf("n32 latency %0d", i), lat, 32'd33);
      checkOutput($sformatf("n32 busy cycles %0d", i), bc, 32'd32);
    end

    // Start while busy is ignored; start during done chains back-to-back.
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = OP_ADD; bus32.a = 32'd1; bus32.b = 32'd1;
    e = '{OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    q32.push_back(e);
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (5) @(negedge clk);
    checkBit("mid-run busy", bus32.busy, 1'b1);
    checkOutput("mid-run result hold", bus32.result, 32'h80000000);
    bus32.start = 1'b1; bus32.a = 32'd9; bus32.b = 32'd9;
    @(negedge clk);
    bus32.start = 1'b0;
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkBit("handshake first done", bus32.done, 1'b1);
    bus32.start = 1'b1; bus32.op = OP_ADD; bus32.a = 32'd4; bus32.b = 32'd4;
    e = '{OP_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    q32.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus32.start = 1'b0;
    end while (bus32.done !== 1'b1 && lat < 60);
    checkOutput("back-to-back latency", lat, 32'd33);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = OP_ADD; bus32.a = 32'h12345678; bus32.b = 32'd1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkBit("mid-op reset busy", bus32.busy, 1'b0);
    checkBit("mid-op reset done", bus32.done, 1'b0);
    checkOutput("mid-op reset result", bus32.result, 32'd0);
    checkBit("mid-op reset cf", bus32.cf, 1'b0);
    checkBit("mid-op reset zf", bus32.zf, 1'b0);
    checkBit("mid-op reset vf", bus32.vf, 1'b0);
    checkBit("mid-op reset sf", bus32.sf, 1'b0);
    rst = 1'b0;
    e = '{OP_ADD, 32'h12345678, 32'd1, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(e, lat, bc);
    checkOutput("post-reset latency", lat, 32'd33);

    // N=8: corner grid for both ops, then random operands.
    for (int op = 0; op < 2; op++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          applyStimulus8(1'(op), corner[i], corner[j]);
        end
      end
    end
    for (int k = 0; k < 200; k++) begin
      applyStimulus8(1'($urandom_range(0, 1)), 8'($urandom()), 8'($urandom()));
    end

    repeat (2) @(negedge clk);
    checkOutput("n32 pending queue", q32.size(), 32'd0);
    checkOutput("n8 pending queue", q8.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor built around a single FA full-adder cell plus a carry flip-flop.
- Processes one bit per clock, LSB first, with start/busy/done handshake.
- Produces the result and RISC-V-style ALU flags (carry, zero, overflow, sign).
- Used as the area-minimal add/sub datapath stage downstream of the FA cell, feeding ALU/branch-compare logic.

Parameters:
- N, 32, operand/result width in bits (N >= 2)
- CW, $clog2(N), bit-counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  N  operand A; sampled with start
- b  input  N  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result/flags valid
- result  output  N  sum/difference; held until next accepted start
- cf  output  1  carry out of MSB (for sub: 1 = no borrow, a >= b unsigned)
- zf  output  1  result == 0
- vf  output  1  signed overflow
- sf  output  1  result[N-1]

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state = IDLE; busy, done, result, cf, zf, vf, sf, count, carry and shift registers all 0. rst has priority over every other input, including mid-operation; a partial operation is discarded.
- FSM states:
  - IDLE: busy = 0, done = 0. On start at edge E0:
    - latch a into a_sh
    - latch (op ? ~b : b) into b_sh
    - carry <= op
    - count <= 0
    - go to RUN
  - RUN: busy = 1. At each edge:
    - FA inputs are a_sh[0], b_sh[0], carry
    - sum shifts into result_sh at the MSB (right shift)
    - a_sh and b_sh shift right; carry <= cout; count++
    - on the edge where count == N-1, record cin_msb = carry (pre-edge value), then go to DONE
  - DONE: busy = 0, done = 1 for exactly one cycle; result, cf, zf, vf, sf are updated on entry.
    - If start is asserted in DONE, it is accepted as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at E0; bits computed at E1..EN; done high in the cycle after EN. Total N+1 cycles from start to done; throughput one operation per N+1 cycles.
- start while busy is ignored (no re-latch, no error). op/a/b may change freely after the accepting edge.
- Flags, computed from the final bit:
  - cf = final cout
  - vf = cin_msb XOR final cout
  - zf = (result == 0)
  - sf = result[N-1]
- result and flags hold their values through IDLE and the next RUN, changing only on the next DONE entry.
- Wrap-around: unsigned modulo 2^N; no saturation.
- Counter is CW bits and must not wrap before reaching N-1.

Decomposition:
- Shared package (alu_pkg):
  - OP_ADD = 1'b0, OP_SUB = 1'b1
  - state encodings S_IDLE, S_RUN, S_DONE (2-bit)
- Sub-module: one instance of the existing single-bit FA cell (ports a, b, cin, sum, cout). Everything else (FSM, shift registers, counter, flag logic) stays in serial_addsub.

Test Plan (N=32 unless noted):
- Add: start, op=0, a=5, b=3 -> done exactly 33 cycles after start; result=8, cf=0, zf=0, vf=0, sf=0; busy high for 32 cycles.
- Add carry/zero: a=0xFFFFFFFF, b=1 -> result=0, cf=1, zf=1, vf=0, sf=0. Then a=0x7FFFFFFF, b=1 -> result=0x80000000, vf=1, sf=1, cf=0.
- Subtract: a=3, b=5, op=1 -> result=0xFFFFFFFE, cf=0, sf=1, vf=0. Then a=5, b=5 -> result=0, zf=1, cf=1. Then a=0x80000000, b=1 -> result=0x7FFFFFFF, vf=1.
- Handshake: pulse start with a=1, b=1; re-pulse start with a=9 mid-RUN -> ignored, result=2. Assert start in the done cycle with a=4, b=4 -> accepted, next done after 33 cycles, result=8.
- Reset mid-op: start a=0x12345678, b=1; assert rst at cycle 10 -> next cycle busy=0, done=0, result=0, all flags 0. New start then completes normally.
- Parameter sweep N=8: exhaustive a, b in 0..255, both ops, compared against a reference model for result and all four flags.
